// File: rtl/mult_seq_nxn.sv
// mult_seq_nxn: sequential shift-add WIDTH x WIDTH multiplier, unsigned or signed per operation.
// Define MULT_EARLY_TERM_EN to finish once the highest set multiplier bit has been consumed.
module mult_seq_nxn #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   O,
  output logic                 busy,
  output logic                 Finish
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, o_q, o_d;
  logic [WIDTH-1:0] mplier_q, mplier_d, abs_a, abs_b;
  logic [CNT_W-1:0] count_q, count_d;
  logic neg_q, neg_d, busy_q, busy_d, finish_q, finish_d, last;
  // Signed operands are multiplied as magnitudes; the most negative value maps to 2^(WIDTH-1).
  assign abs_a = (signed_mode & A[WIDTH-1]) ? -A : A;
  assign abs_b = (signed_mode & B[WIDTH-1]) ? -B : B;
`ifdef MULT_EARLY_TERM_EN
  assign last = (count_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last = count_q == CNT_W'(WIDTH - 1);
`endif
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    neg_d    = neg_q;
    o_d      = o_q;
    busy_d   = busy_q;
    finish_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        mcand_d  = {{WIDTH{1'b0}}, abs_a};
        mplier_d = abs_b;
        neg_d    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
        prod_d   = '0;
        count_d  = '0;
        busy_d   = 1'b1;
        state_d  = CALC;
      end
      CALC: begin
        prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        state_d  = last ? DONE : CALC;
      end
      DONE: begin
        o_d      = neg_q ? ~prod_q + 1'b1 : prod_q;
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      o_q      <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      o_q      <= o_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end
  assign O      = o_q;
  assign busy   = busy_q;
  assign Finish = finish_q;
endmodule
